// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the stopwatch button front end: the debounce FSM
// encoding and the default timing constants for a 1 MHz system clock.
package button_conditioner_pkg;

   // Per-channel debounce state
   typedef enum logic [1:0] {
      StLow      = 2'b00,
      StRiseWait = 2'b01,
      StHigh     = 2'b10,
      StFallWait = 2'b11
   } btn_state_e;

   // 10 ms debounce window, 1 s hold time at 1 MHz
   localparam int unsigned DefDebounceCycles = 10000;
   localparam int unsigned DefHoldCycles     = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, LOW/RISE_WAIT/HIGH/FALL_WAIT
// debounce FSM, debounce counter and hold counter. All pulses are registered.
module debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned HOLD_CYCLES     = DefHoldCycles
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic hold_pulse
);

   localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HoldW = $clog2(HOLD_CYCLES);

   localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DebW-1:0]  DebOne   = DebW'(1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
   localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

   logic              meta_q;
   logic              s_q;
   btn_state_e        state_q, state_d;
   logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
   logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
   logic              press_d, release_d, hold_d;
   logic              press_q, release_q, hold_q;
   logic              deb_done;
   logic              in_high;

   assign deb_done = (deb_cnt_q == DebLast);
   assign in_high  = (state_q == StHigh) || (state_q == StFallWait);

   // Synchronize the raw asynchronous level; only s_q is used downstream
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         s_q    <= 1'b0;
      end else begin
         meta_q <= btn_raw;
         s_q    <= meta_q;
      end
   end

   // State, counter and pulse registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StLow;
         deb_cnt_q  <= '0;
         hold_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         hold_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         deb_cnt_q  <= deb_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         hold_q     <= hold_d;
      end
   end

   // Next-state logic of the debounce FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLow: begin
            if (s_q) state_d = StRiseWait;
         end
         StRiseWait: begin
            if (!s_q)         state_d = StLow;
            else if (deb_done) state_d = StHigh;
         end
         StHigh: begin
            if (!s_q) state_d = StFallWait;
         end
         StFallWait: begin
            if (s_q)           state_d = StHigh;
            else if (deb_done) state_d = StLow;
         end
         default: state_d = StLow;
      endcase
   end

   // Debounce and hold counter updates; both stop short of wrapping
   always_comb begin
      deb_cnt_d  = deb_cnt_q;
      hold_cnt_d = hold_cnt_q;
      unique case (state_q)
         StLow: begin
            if (s_q) deb_cnt_d = '0;
         end
         StRiseWait: begin
            if (s_q && !deb_done) deb_cnt_d = deb_cnt_q + DebOne;
            else                  deb_cnt_d = '0;
         end
         StHigh: begin
            if (!s_q) deb_cnt_d = '0;
         end
         StFallWait: begin
            if (!s_q && !deb_done) deb_cnt_d = deb_cnt_q + DebOne;
            else                   deb_cnt_d = '0;
         end
         default: deb_cnt_d = '0;
      endcase
      // A bounce back from FALL_WAIT keeps the hold count running
      if (state_q == StRiseWait && state_d == StHigh) begin
         hold_cnt_d = '0;
      end else if (in_high && hold_cnt_q != HoldLast) begin
         hold_cnt_d = hold_cnt_q + HoldOne;
      end
   end

   // Pulse next values and the debounced level
   always_comb begin
      press_d   = (state_q == StRiseWait) && (state_d == StHigh);
      release_d = (state_q == StFallWait) && (state_d == StLow);
      hold_d    = in_high && (hold_cnt_q != HoldLast) && (hold_cnt_d == HoldLast);
      level     = in_high;
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign hold_pulse    = hold_q;

endmodule

// File: rtl/button_conditioner.sv
// Three independent debounced stopwatch buttons:
// [0] start_stop, [1] lap_time, [2] counter reset.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned HOLD_CYCLES     = DefHoldCycles
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] btn_in,
   output logic [2:0] level,
   output logic [2:0] press_pulse,
   output logic [2:0] release_pulse,
   output logic [2:0] hold_pulse
);

   // Counters need at least one bit and the hold must outlast the debounce
   if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES <= DEBOUNCE_CYCLES) begin : gen_param_check
      $error("button_conditioner: need DEBOUNCE_CYCLES>=2 and HOLD_CYCLES>DEBOUNCE_CYCLES");
   end

   for (genvar i = 0; i < 3; i++) begin : gen_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES)
      ) u_chan (
         .clk           (clk),
         .rst_n         (rst_n),
         .btn_raw       (btn_in[i]),
         .level         (level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .hold_pulse    (hold_pulse[i])
      );
   end

endmodule
